core_dmem_resp: RTL and testbench
=================================

// Module: core_dmem_resp
// PURPOSE
//  Data-memory responder: the target side of the EX-stage LSU load/store request channel.
//  Accepts one request at a time over valid/ready and performs a byte-masked word write or a
//  word read against an internal XLEN-wide array. Returns the read data and status after a fixed
//  latency over a second valid/ready channel.
//  Serves as the synthesizable replacement for the DPI-C data-memory model in simulation/FPGA tops.
// PARAMETERS
//  XLEN      64    data width; must be 64 (wmask is 8 bits)
//  ADDR_W    32    byte-address width
//  DEPTH     1024  number of XLEN words; power of two
//  LATENCY   2     cycles from the accept edge to rsp_valid rising; legal range 1..15
// PORTS
//  clk        in   1       clock; all state updates on its rising edge
//  rst        in   1       reset, asynchronous assert, active-high
//  req_valid  in   1       request present
//  req_ready  out  1       responder can accept a request
//  req_wen    in   1       1 = store, 0 = load
//  req_size   in   2       0 = B, 1 = H, 2 = W, 3 = D
//  req_addr   in   ADDR_W  byte address
//  req_wdata  in   XLEN    store data, already lane-aligned
//  req_wmask  in   8       byte enables for stores; ignored for loads
//  rsp_valid  out  1       response present
//  rsp_ready  in   1       consumer takes the response
//  rsp_rdata  out  XLEN    full addressed word (loads); 0 for stores
//  rsp_err    out  1       access fault; valid only with rsp_valid
// BEHAVIOUR
//  - Reset values: req_ready=1, rsp_valid=0, rsp_rdata=0, rsp_err=0, FSM=IDLE, cnt=0.
//  - Reset does not clear array contents.
//  - Word index = req_addr[log2(DEPTH)+2:3]; higher address bits are ignored, so addresses wrap
//    modulo DEPTH*8.
//  - FSM states:
//    - IDLE: req_ready=1. On accept (req_valid & req_ready):
//      - store without error: write bytes where wmask[i]=1.
//      - load: read the word into rsp_rdata.
//      - err: computed and latched into rsp_err.
//      - cnt is loaded with LATENCY-1.
//      - next state: WAIT if LATENCY>1, otherwise RESP.
//    - WAIT: req_ready=0. cnt decrements each cycle; when cnt==1, go to RESP on the next edge.
//    - RESP: rsp_valid=1; rsp_rdata and rsp_err are held stable. On rsp_ready, go to IDLE.
//  - Latency: rsp_valid rises exactly LATENCY cycles after the accept edge.
//  - Throughput: at most 1 request per LATENCY+1 cycles. A request cannot be accepted in the
//    same cycle a response completes; req_ready rises the cycle after the RESP handshake.
//  - Ordering: a store commits at its accept edge, so a following load to the same word returns
//    the new data.
//  - A store with wmask=0 is legal: no write, rsp_err=0.
//  - A load with a nonzero wmask ignores the mask.
//  - req_* may change freely while req_ready=0; they are not sampled.
//  - rsp_ready held high before RESP has no effect.
//  - rst asserted mid-operation:
//    - the in-flight request is dropped and no response is produced;
//    - a store already accepted remains written.
// CONFIGURATION
//  CORE_DMEM_ALIGN_CHECK_EN defined:
//   - rsp_err=1 when req_addr mod (1<<req_size) != 0.
//   - a faulting store writes nothing.
//   - a faulting load returns rsp_rdata=0.
//  CORE_DMEM_ALIGN_CHECK_EN undefined:
//   - no alignment check; rsp_err is tied to 0.
//   - misaligned accesses operate on the containing word.
// STRUCTURE
//  core_defines.v gains:
//   - CORE_DMEM_SIZE_B/H/W/D encodings
//   - FSM state encodings CORE_DMEM_ST_IDLE/WAIT/RESP (2 bits)
//  Flops are gnrl_dffr / gnrl_dfflr instances for: state, cnt, rsp_rdata, rsp_err.
//  One sub-module, core_dmem_ram: DEPTH x XLEN array with byte write enables, one combinational
//  read port and one write port.
// TESTING
//  1. Reset, then store addr=0x10, wdata=0x1122334455667788, wmask=0xFF, LATENCY=2
//     -> rsp_valid at cycle +2, rsp_err=0, rsp_rdata=0.
//  2. Load addr=0x10 -> rsp_rdata=0x1122334455667788. Then store addr=0x10, wdata=0xAA,
//     wmask=0x01; load again -> 0x11223344556677AA.
//  3. Hold rsp_ready=0 for 5 cycles in RESP -> rsp_valid, rsp_rdata, rsp_err stable and
//     req_ready=0 throughout; req_ready=1 the cycle after the handshake.
//  4. With CORE_DMEM_ALIGN_CHECK_EN: store size=W, addr=0x12, wmask=0x3C -> rsp_err=1 and the
//     word at 0x10 is unchanged. Without the macro -> rsp_err=0 and the write occurs.
//  5. Wrap: with DEPTH=1024, store to addr=0x2010, then load addr=0x10 -> returns the stored data.
//  6. Assert rst during WAIT -> rsp_valid never rises, req_ready=1 on the first edge after rst
//     deasserts, and the next request completes normally.

Source files
------------

// File: rtl/core_dmem_resp_pkg.sv
// Shared encodings and the alignment helper for the data-memory responder.
package core_dmem_resp_pkg;

    localparam logic [1:0] CORE_DMEM_SIZE_B = 2'd0;
    localparam logic [1:0] CORE_DMEM_SIZE_H = 2'd1;
    localparam logic [1:0] CORE_DMEM_SIZE_W = 2'd2;
    localparam logic [1:0] CORE_DMEM_SIZE_D = 2'd3;

    localparam logic [1:0] CORE_DMEM_ST_IDLE = 2'd0;
    localparam logic [1:0] CORE_DMEM_ST_WAIT = 2'd1;
    localparam logic [1:0] CORE_DMEM_ST_RESP = 2'd2;

    // True when the byte offset within the word is not a multiple of the access size.
    function automatic logic core_dmem_misaligned(input logic [1:0] size, input logic [2:0] addr_lo);
        logic mis;
        case (size)
            CORE_DMEM_SIZE_B: mis = 1'b0;
            CORE_DMEM_SIZE_H: mis = addr_lo[0];
            CORE_DMEM_SIZE_W: mis = |addr_lo[1:0];
            default:          mis = |addr_lo;
        endcase
        return mis;
    endfunction

endpackage

// File: rtl/core_dmem_ram.sv
// DEPTH x XLEN word array: byte-enabled synchronous write, combinational read, same address.
module core_dmem_ram #(
    parameter int XLEN  = 64,
    parameter int DEPTH = 1024,
    parameter int AW    = 10
) (
    input  logic              clk,
    input  logic              we,
    input  logic [XLEN/8-1:0] wmask,
    input  logic [AW-1:0]     addr,
    input  logic [XLEN-1:0]   wdata,
    output logic [XLEN-1:0]   rdata
);

    logic [XLEN-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        for (int i = 0; i < XLEN/8; i++) begin
            if (we && wmask[i]) begin
                mem[addr][i*8 +: 8] <= wdata[i*8 +: 8];
            end
        end
    end

    assign rdata = mem[addr];

endmodule

// File: rtl/core_dmem_resp.sv
// Data-memory responder: one request at a time, response after LATENCY cycles.
// Optional alignment fault checking is enabled with CORE_DMEM_ALIGN_CHECK_EN.
module core_dmem_resp
    import core_dmem_resp_pkg::*;
#(
    parameter int XLEN    = 64,
    parameter int ADDR_W  = 32,
    parameter int DEPTH   = 1024,
    parameter int LATENCY = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_wen,
    input  logic [1:0]        req_size,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [XLEN-1:0]   req_wdata,
    input  logic [7:0]        req_wmask,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [XLEN-1:0]   rsp_rdata,
    output logic              rsp_err
);

    localparam int AW = $clog2(DEPTH);

    logic [1:0]      state;
    logic [3:0]      cnt;
    logic            accept;
    logic            req_fault;
    logic [AW-1:0]   word_idx;
    logic [XLEN-1:0] ram_rdata;
    logic            unused_bits;

    assign req_ready = (state == CORE_DMEM_ST_IDLE);
    assign rsp_valid = (state == CORE_DMEM_ST_RESP);
    assign accept    = req_valid & req_ready;
    // Upper address bits are dropped so accesses wrap modulo DEPTH*8 bytes.
    assign word_idx  = req_addr[AW+2:3];
    assign unused_bits = ^{req_addr[ADDR_W-1:AW+3], req_addr[2:0], req_size};

`ifdef CORE_DMEM_ALIGN_CHECK_EN
    assign req_fault = core_dmem_misaligned(req_size, req_addr[2:0]);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rsp_err <= 1'b0;
        end else if (accept) begin
            rsp_err <= req_fault;
        end
    end
`else
    assign req_fault = 1'b0;
    assign rsp_err   = 1'b0;
`endif

    core_dmem_ram #(
        .XLEN  (XLEN),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_ram (
        .clk   (clk),
        .we    (accept & req_wen & ~req_fault),
        .wmask (req_wmask),
        .addr  (word_idx),
        .wdata (req_wdata),
        .rdata (ram_rdata)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= CORE_DMEM_ST_IDLE;
            cnt       <= 4'd0;
            rsp_rdata <= '0;
        end else begin
            case (state)
                CORE_DMEM_ST_IDLE: begin
                    if (accept) begin
                        cnt       <= 4'(LATENCY - 1);
                        // Stores and faulting loads return zero data.
                        rsp_rdata <= (req_wen || req_fault) ? '0 : ram_rdata;
                        state     <= (LATENCY > 1) ? CORE_DMEM_ST_WAIT : CORE_DMEM_ST_RESP;
                    end
                end
                CORE_DMEM_ST_WAIT: begin
                    cnt <= cnt - 4'd1;
                    if (cnt == 4'd1) begin
                        state <= CORE_DMEM_ST_RESP;
                    end
                end
                CORE_DMEM_ST_RESP: begin
                    if (rsp_ready) begin
                        state <= CORE_DMEM_ST_IDLE;
                    end
                end
                default: state <= CORE_DMEM_ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_core_dmem_resp.sv
// Directed bench for core_dmem_resp (LATENCY=2, DEPTH=1024); honours CORE_DMEM_ALIGN_CHECK_EN.
module tb_core_dmem_resp;

    localparam int LAT = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_wen = 1'b0;
    logic [1:0]  req_size = 2'd3;
    logic [31:0] req_addr = '0;
    logic [63:0] req_wdata = '0;
    logic [7:0]  req_wmask = '0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [63:0] rsp_rdata;
    logic        rsp_err;

    int checks = 0;
    int errors = 0;

    int          r_cyc;
    logic [63:0] r_data;
    logic        r_err;
    bit          r_to;

    always #5 clk = ~clk;

    core_dmem_resp #(
        .XLEN(64), .ADDR_W(32), .DEPTH(1024), .LATENCY(LAT)
    ) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_wen(req_wen),
        .req_size(req_size), .req_addr(req_addr), .req_wdata(req_wdata),
        .req_wmask(req_wmask), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_rdata(rsp_rdata), .rsp_err(rsp_err)
    );

    // Present a request for exactly one rising edge; caller ensures the DUT is idle.
    task automatic issue(input logic wen, input logic [1:0] size, input logic [31:0] addr,
                         input logic [63:0] wdata, input logic [7:0] wmask);
        req_valid = 1'b1;
        req_wen   = wen;
        req_size  = size;
        req_addr  = addr;
        req_wdata = wdata;
        req_wmask = wmask;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        req_wdata = 64'hDEAD_BEEF_DEAD_BEEF;
        req_addr  = 32'hFFFF_FFF8;
    endtask

    // Count sample points until rsp_valid, capture, then complete the handshake.
    task automatic wait_rsp(output int cyc, output logic [63:0] data, output logic err,
                            output bit timeout);
        cyc = 0;
        timeout = 1'b1;
        data = '0;
        err = 1'b0;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (rsp_valid === 1'b1) begin
                cyc = i;
                timeout = 1'b0;
                break;
            end
        end
        if (!timeout) begin
            data = rsp_rdata;
            err  = rsp_err;
            rsp_ready = 1'b1;
            @(posedge clk);
            #1;
            rsp_ready = 1'b0;
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL reset_req_ready got %b exp 1", req_ready); end
        checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid got %b exp 0", rsp_valid); end
        checks++; if (rsp_rdata !== 64'h0) begin errors++; $display("FAIL reset_rsp_rdata got %h exp 0", rsp_rdata); end
        checks++; if (rsp_err !== 1'b0) begin errors++; $display("FAIL reset_rsp_err got %b exp 0", rsp_err); end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_store;
        issue(1'b1, 2'd3, 32'h10, 64'h1122_3344_5566_7788, 8'hFF);
        wait_rsp(r_cyc, r_data, r_err, r_to);
        checks++; if (r_to || r_cyc != LAT) begin errors++; $display("FAIL store_latency got %0d exp %0d", r_cyc, LAT); end
        checks++; if (r_err !== 1'b0) begin errors++; $display("FAIL store_err got %b exp 0", r_err); end
        checks++; if (r_data !== 64'h0) begin errors++; $display("FAIL store_rdata got %h exp 0", r_data); end
    endtask

    task automatic test_load_and_partial_store;
        issue(1'b0, 2'd3, 32'h10, 64'h0, 8'h00);
        wait_rsp(r_cyc, r_data, r_err, r_to);
        checks++; if (r_to || r_data !== 64'h1122_3344_5566_7788) begin errors++; $display("FAIL load1_rdata got %h exp 1122334455667788", r_data); end
        checks++; if (r_cyc != LAT) begin errors++; $display("FAIL load1_latency got %0d exp %0d", r_cyc, LAT); end
        issue(1'b1, 2'd0, 32'h10, 64'hAA, 8'h01);
        wait_rsp(r_cyc, r_data, r_err, r_to);
        checks++; if (r_to || r_data !== 64'h0) begin errors++; $display("FAIL bstore_rdata got %h exp 0", r_data); end
        // A load carrying a nonzero mask must still return the whole word.
        issue(1'b0, 2'd3, 32'h10, 64'h0, 8'h0F);
        wait_rsp(r_cyc, r_data, r_err, r_to);
        checks++; if (r_to || r_data !== 64'h1122_3344_5566_77AA) begin errors++; $display("FAIL load2_rdata got %h exp 11223344556677AA", r_data); end
        // wmask=0 store leaves the word alone.
        issue(1'b1, 2'd3, 32'h10, 64'hFFFF_FFFF_FFFF_FFFF, 8'h00);
        wait_rsp(r_cyc, r_data, r_err, r_to);
        checks++; if (r_to || r_err !== 1'b0) begin errors++; $display("FAIL zmask_err got %b exp 0", r_err); end
        issue(1'b0, 2'd3, 32'h10, 64'h0, 8'h00);
        wait_rsp(r_cyc, r_data, r_err, r_to);
        checks++; if (r_to || r_data !== 64'h1122_3344_5566_77AA) begin errors++; $display("FAIL zmask_rdata got %h exp 11223344556677AA", r_data); end
    endtask

    task automatic test_backpressure;
        logic [63:0] d0;
        logic        e0;
        bit          seen;
        issue(1'b0, 2'd3, 32'h10, 64'h0, 8'h00);
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (rsp_valid === 1'b1) begin seen = 1'b1; break; end
        end
        checks++; if (!seen) begin errors++; $display("FAIL bp_rsp_valid timeout got 0 exp 1"); end
        d0 = rsp_rdata;
        e0 = rsp_err;
        checks++; if (d0 !== 64'h1122_3344_5566_77AA) begin errors++; $display("FAIL bp_rdata got %h exp 11223344556677AA", d0); end
        // Garbage request held while busy must not be taken.
        req_valid = 1'b1; req_wen = 1'b1; req_addr = 32'h10; req_wdata = 64'h0; req_wmask = 8'hFF;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checks++; if (rsp_valid !== 1'b1) begin errors++; $display("FAIL bp_hold_valid c%0d got %b exp 1", i, rsp_valid); end
            checks++; if (rsp_rdata !== d0) begin errors++; $display("FAIL bp_hold_rdata c%0d got %h exp %h", i, rsp_rdata, d0); end
            checks++; if (rsp_err !== e0) begin errors++; $display("FAIL bp_hold_err c%0d got %b exp %b", i, rsp_err, e0); end
            checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL bp_hold_req_ready c%0d got %b exp 0", i, req_ready); end
        end
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        rsp_ready = 1'b0;
        checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL bp_ready_after got %b exp 1", req_ready); end
        checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL bp_valid_after got %b exp 0", rsp_valid); end
        issue(1'b0, 2'd3, 32'h10, 64'h0, 8'h00);
        wait_rsp(r_cyc, r_data, r_err, r_to);
        checks++; if (r_to || r_data !== 64'h1122_3344_5566_77AA) begin errors++; $display("FAIL bp_unsampled_store got %h exp 11223344556677AA", r_data); end
    endtask

    task automatic test_align;
        logic        exp_err;
        logic [63:0] exp_word;
        logic [63:0] exp_hload;
`ifdef CORE_DMEM_ALIGN_CHECK_EN
        exp_err   = 1'b1;
        exp_word  = 64'h1122_3344_5566_77AA;
        exp_hload = 64'h0;
`else
        exp_err   = 1'b0;
        exp_word  = 64'h1122_CAFE_BABE_77AA;
        exp_hload = 64'h1122_CAFE_BABE_77AA;
`endif
        issue(1'b1, 2'd2, 32'h12, 64'h0000_CAFE_BABE_0000, 8'h3C);
        wait_rsp(r_cyc, r_data, r_err, r_to);
        checks++; if (r_to || r_err !== exp_err) begin errors++; $display("FAIL align_store_err got %b exp %b", r_err, exp_err); end
        issue(1'b0, 2'd3, 32'h10, 64'h0, 8'h00);
        wait_rsp(r_cyc, r_data, r_err, r_to);
        checks++; if (r_to || r_data !== exp_word) begin errors++; $display("FAIL align_word got %h exp %h", r_data, exp_word); end
        checks++; if (r_err !== 1'b0) begin errors++; $display("FAIL align_aligned_err got %b exp 0", r_err); end
        issue(1'b0, 2'd1, 32'h11, 64'h0, 8'h00);
        wait_rsp(r_cyc, r_data, r_err, r_to);
        checks++; if (r_to || r_err !== exp_err) begin errors++; $display("FAIL align_load_err got %b exp %b", r_err, exp_err); end
        checks++; if (r_data !== exp_hload) begin errors++; $display("FAIL align_load_rdata got %h exp %h", r_data, exp_hload); end
    endtask

    task automatic test_wrap;
        issue(1'b1, 2'd3, 32'h2010, 64'h0BAD_F00D_1357_9BDF, 8'hFF);
        wait_rsp(r_cyc, r_data, r_err, r_to);
        checks++; if (r_to) begin errors++; $display("FAIL wrap_store timeout got 0 exp 1"); end
        issue(1'b0, 2'd3, 32'h10, 64'h0, 8'h00);
        wait_rsp(r_cyc, r_data, r_err, r_to);
        checks++; if (r_to || r_data !== 64'h0BAD_F00D_1357_9BDF) begin errors++; $display("FAIL wrap_load got %h exp 0BADF00D13579BDF", r_data); end
    endtask

    task automatic test_reset_mid;
        bit rose;
        issue(1'b1, 2'd3, 32'h40, 64'h0000_0000_0000_1234, 8'hFF);
        // Now in WAIT; assert reset asynchronously away from the clock edge.
        #2;
        rst = 1'b1;
        rose = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (rsp_valid !== 1'b0) rose = 1'b1;
        end
        checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL rstmid_ready_in_rst got %b exp 1", req_ready); end
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (rsp_valid !== 1'b0) rose = 1'b1;
        end
        checks++; if (rose) begin errors++; $display("FAIL rstmid_no_rsp got 1 exp 0"); end
        checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL rstmid_ready_after got %b exp 1", req_ready); end
        issue(1'b0, 2'd3, 32'h40, 64'h0, 8'h00);
        wait_rsp(r_cyc, r_data, r_err, r_to);
        checks++; if (r_to || r_cyc != LAT) begin errors++; $display("FAIL rstmid_next_latency got %0d exp %0d", r_cyc, LAT); end
        checks++; if (r_data !== 64'h1234) begin errors++; $display("FAIL rstmid_store_kept got %h exp 1234", r_data); end
    endtask

    initial begin
        test_reset();
        test_store();
        test_load_and_partial_store();
        test_backpressure();
        test_align();
        test_wrap();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
